// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the operand/counter widths, the Booth register width, the FSM state
// encoding and a magnitude helper used when loading the divider.
package multdiv_pkg;

    localparam int WIDTH   = 32;
    localparam int CNT_W   = 5;
    // {acc[WIDTH:0], Q[WIDTH-1:0], q_m1}. The accumulator carries one guard
    // bit so that adding or subtracting INT_MIN can never overflow it.
    localparam int BOOTH_W = 2 * WIDTH + 2;

    localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // INT_MIN maps to 0x80000000, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/multdiv_if.sv
// Core-side bus of the multiply/divide unit.
// master: core pipeline (drives operands and start pulses, reads results)
// slave : multdiv_iter   (reads operands and start pulses, drives results)
interface multdiv_if;
    import multdiv_pkg::*;

    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );

endinterface

// File: rtl/multdiv_booth_step.sv
// One radix-2 Booth iteration, purely combinational.
// booth_in  : {acc[32:0], Q[31:0], q_m1} before the step
// mcand     : multiplicand, signed
// booth_out : register after add/subtract and arithmetic shift right by one
module booth_step
    import multdiv_pkg::*;
(
    input  logic [BOOTH_W-1:0] booth_in,
    input  logic [WIDTH-1:0]   mcand,
    output logic [BOOTH_W-1:0] booth_out
);

    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] acc;
    logic [WIDTH:0] acc_sum;

    always_comb begin
        m_ext = {mcand[WIDTH-1], mcand};
        acc   = booth_in[BOOTH_W-1:WIDTH+1];
        case (booth_in[1:0])
            2'b01:   acc_sum = acc + m_ext;
            2'b10:   acc_sum = acc - m_ext;
            default: acc_sum = acc;
        endcase
        // Shift drops the old q_m1; Q[0] becomes the new q_m1.
        booth_out = {acc_sum[WIDTH], acc_sum, booth_in[WIDTH:1]};
    end

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit multiply (radix-2 Booth) and divide (non-restoring
// on magnitudes, sign-corrected quotient). Each operation takes 32 steps;
// the result and exception flag are registered and presented with a one-cycle
// data_resultRDY pulse 33 cycles after the start edge.
// Ports: clock, reset (sync, active-high), bus (multdiv_if.slave).
//
// state   | meaning
// IDLE    | waiting for a start pulse
// MUL     | one Booth step per cycle
// DIV     | one non-restoring step per cycle
// DONE    | final step done; outputs load and RDY pulses on leaving
module multdiv_iter
    import multdiv_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    multdiv_if.slave  bus
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [BOOTH_W-1:0] booth_q, booth_next;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   quo_q, quo_next, divisor_q;
    logic [WIDTH+1:0]   rem_q, rem_shift, rem_next;
    logic               op_mul_q, div_neg_q, div_zero_q, div_ovf_q;
    logic               start_mul, start_div, finish;
    logic [WIDTH:0]     prod_hi;
    logic               mul_ovf;
    logic [WIDTH-1:0]   result_q;
    logic               exc_q, rdy_q;
    logic               unused_bits;

    booth_step u_booth_step (
        .booth_in  (booth_q),
        .mcand     (mcand_q),
        .booth_out (booth_next)
    );

    always_comb begin
        start_mul = bus.ctrl_MULT;
        start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
        finish    = 1'b0;
        state_d   = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_MUL, ST_DIV: begin
                if (&cnt_q) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                finish  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // A new start aborts whatever is in flight, including a pending RDY.
        if (start_mul) begin
            state_d = ST_MUL;
            finish  = 1'b0;
        end else if (start_div) begin
            state_d = ST_DIV;
            finish  = 1'b0;
        end
    end

    // Non-restoring step: remainder sign picks add or subtract; quotient bit
    // is the complement of the new remainder sign. Only the remainder would
    // need a final correction, and it is discarded.
    always_comb begin
        rem_shift = {rem_q[WIDTH:0], quo_q[WIDTH-1]};
        rem_next  = rem_q[WIDTH+1] ? rem_shift + {2'b00, divisor_q}
                                   : rem_shift - {2'b00, divisor_q};
        quo_next  = {quo_q[WIDTH-2:0], ~rem_next[WIDTH+1]};
    end

    // Product bit i sits at booth_q[i+1]; product[63:31] must be a pure
    // sign extension for the result to fit in 32 signed bits.
    assign prod_hi     = booth_q[2*WIDTH:WIDTH];
    assign mul_ovf     = ~((&prod_hi) | ~(|prod_hi));
    assign unused_bits = booth_q[BOOTH_W-1] ^ booth_q[0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            booth_q    <= '0;
            mcand_q    <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            op_mul_q   <= 1'b0;
            div_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            div_ovf_q  <= 1'b0;
            result_q   <= '0;
            exc_q      <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= finish;
            if (start_mul) begin
                cnt_q    <= '0;
                op_mul_q <= 1'b1;
                mcand_q  <= bus.data_operandA;
                booth_q  <= {{(WIDTH+1){1'b0}}, bus.data_operandB, 1'b0};
            end else if (start_div) begin
                cnt_q      <= '0;
                op_mul_q   <= 1'b0;
                quo_q      <= magnitude(bus.data_operandA);
                divisor_q  <= magnitude(bus.data_operandB);
                rem_q      <= '0;
                div_neg_q  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                div_zero_q <= (bus.data_operandB == '0);
                div_ovf_q  <= (bus.data_operandA == INT_MIN) && (bus.data_operandB == '1);
            end else if (state_q == ST_MUL) begin
                booth_q <= booth_next;
                cnt_q   <= cnt_q + CNT_W'(1);
            end else if (state_q == ST_DIV) begin
                rem_q <= rem_next;
                quo_q <= quo_next;
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (finish) begin
                if (op_mul_q) begin
                    result_q <= booth_q[WIDTH:1];
                    exc_q    <= mul_ovf;
                end else if (div_zero_q) begin
                    result_q <= '0;
                    exc_q    <= 1'b1;
                end else begin
                    // INT_MIN / -1 yields magnitude 0x80000000 with positive
                    // sign, which already reads back as INT_MIN.
                    result_q <= div_neg_q ? -quo_q : quo_q;
                    exc_q    <= div_ovf_q;
                end
            end
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_iter.sv
module tb_multdiv_iter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    multdiv_if bus();

    multdiv_iter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected-output model state
    int          due      = -1;
    logic [31:0] exp_res  = '0;
    logic        exp_exc  = 1'b0;
    logic [31:0] hold_res = '0;
    logic        hold_exc = 1'b0;
    bit          chk_en   = 1'b0;
    int          last_start = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Returns {exception, result} from plain signed arithmetic.
    function automatic logic [32:0] model(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
        longint      p;
        logic [31:0] q;
        if (is_mul) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return {(p != longint'($signed(p[31:0]))), p[31:0]};
        end
        if (b == 32'h0)
            return {1'b1, 32'h0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {1'b1, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        return {1'b0, q};
    endfunction

    // Single compare process: RDY every cycle, results on RDY, hold otherwise.
    always @(negedge clock) begin
        if (chk_en) begin
            if (cyc == due) begin
                check("rdy_pulse", {31'b0, bus.data_resultRDY}, 32'd1);
                check("result", bus.data_result, exp_res);
                check("exception", {31'b0, bus.data_exception}, {31'b0, exp_exc});
                hold_res = exp_res;
                hold_exc = exp_exc;
            end else begin
                check("rdy_idle", {31'b0, bus.data_resultRDY}, 32'd0);
                check("hold_result", bus.data_result, hold_res);
                check("hold_exception", {31'b0, bus.data_exception}, {31'b0, hold_exc});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    // Pins the model against hand-computed values.
    task automatic pin(input string name, input bit is_mul, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] lit_res, input bit lit_exc);
        logic [32:0] m;
        m = model(is_mul, a, b);
        check({name, "_model_res"}, m[31:0], lit_res);
        check({name, "_model_exc"}, {31'b0, m[32]}, {31'b0, lit_exc});
    endtask

    task automatic start(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] m;
        @(negedge clock);
        #1;
        m = model(mul, a, b);
        bus.ctrl_MULT     = mul;
        bus.ctrl_DIV      = div;
        bus.data_operandA = a;
        bus.data_operandB = b;
        exp_res    = m[31:0];
        exp_exc    = m[32];
        last_start = cyc;
        due        = cyc + 34;
        @(negedge clock);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom();
        bus.data_operandB = $urandom();
    endtask

    initial begin
        logic [31:0] ra, rb;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (3) @(negedge clock);
        #1;
        chk_en = 1'b1;
        reset  = 1'b0;

        pin("mul_basic", 1, 32'd7, -32'sd3, 32'hFFFF_FFEB, 0);
        start(1, 0, 32'd7, -32'sd3);
        idle(36);

        pin("mul_ovf16", 1, 32'h0001_0000, 32'h0001_0000, 32'h0, 1);
        start(1, 0, 32'h0001_0000, 32'h0001_0000);
        idle(36);
        pin("mul_intmin_neg1", 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        start(1, 0, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(36);
        pin("mul_intmin_sq", 1, 32'h8000_0000, 32'h8000_0000, 32'h0, 1);
        start(1, 0, 32'h8000_0000, 32'h8000_0000);
        idle(36);

        pin("div_m17_5", 0, -32'sd17, 32'd5, 32'hFFFF_FFFD, 0);
        start(0, 1, -32'sd17, 32'd5);
        idle(36);
        pin("div_17_m5", 0, 32'd17, -32'sd5, 32'hFFFF_FFFD, 0);
        start(0, 1, 32'd17, -32'sd5);
        idle(36);
        pin("div_m17_m5", 0, -32'sd17, -32'sd5, 32'd3, 0);
        start(0, 1, -32'sd17, -32'sd5);
        idle(36);
        pin("div_by_zero", 0, 32'd123, 32'd0, 32'd0, 1);
        start(0, 1, 32'd123, 32'd0);
        idle(36);
        pin("div_intmin_neg1", 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        start(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(36);
        pin("div_intmin_self", 0, 32'h8000_0000, 32'h8000_0000, 32'd1, 0);
        start(0, 1, 32'h8000_0000, 32'h8000_0000);
        idle(36);

        // Abort a multiply around cycle 10 with a divide
        pin("abort_div", 0, 32'd100, 32'd7, 32'd14, 0);
        start(1, 0, 32'd6, 32'd7);
        idle(8);
        start(0, 1, 32'd100, 32'd7);
        idle(36);

        // Both pulses together: multiply wins
        pin("both_pulses", 1, 32'd6, 32'd3, 32'd18, 0);
        start(1, 1, 32'd6, 32'd3);
        idle(36);

        // Restart while sitting in DONE: the pending RDY must not appear
        start(1, 0, 32'd5, 32'd5);
        idle(31);
        pin("done_abort", 0, 32'd1000, -32'sd10, 32'hFFFF_FF9C, 0);
        start(0, 1, 32'd1000, -32'sd10);
        idle(36);

        // Reset in the middle of a multiply
        start(1, 0, 32'd1234, 32'd5678);
        idle(19);
        reset    = 1'b1;
        due      = -1;
        hold_res = '0;
        hold_exc = 1'b0;
        idle(1);
        reset = 1'b0;
        idle(40);
        pin("after_reset", 1, 32'd1234, 32'd5678, 32'h006A_E9BC, 0);
        start(1, 0, 32'd1234, 32'd5678);
        idle(36);

        // Mixed vectors checked by the model alone
        for (int i = 0; i < 8; i++) begin
            ra = $urandom();
            rb = (i % 2 == 0) ? $urandom() : $urandom_range(1, 1000);
            if (i % 4 == 3) rb = -rb;
            start(i % 2 == 0, i % 2 == 1, ra, rb);
            idle(36);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
